// File: rtl/arbiter_pkg.sv
// Shared types and constants for the round-robin request arbiter.
// Imported by the search and arbiter control modules.
package arbiter_pkg;

   localparam int NREQ           = 4;
   localparam int IDX_W          = 2;
   localparam int CNT_W          = 3;
   localparam int MAX_TENURE_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Wrap-around priority search: first set request at or after start.
// Purely combinational.
module rr_priority_pick
   import arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] winner,
   output logic             found
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = start + IDX_W'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/request_arbiter.sv
// Round-robin arbiter with bounded tenure; registered outputs
// feed a 2-to-4 decoder directly.
module request_arbiter
   import arbiter_pkg::*;
#(
   parameter int MAX_TENURE = MAX_TENURE_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   output logic       address0,
   output logic       address1,
   output logic       enable
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TENURE);

   state_t           state, state_n;
   logic [IDX_W-1:0] addr, addr_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             en_q, en_n;

   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] win;
   logic             found;
   logic             held;
   logic             others;

   // The pointer always equals the current owner while granted,
   // so one search from pointer+1 serves both idle and rotation.
   assign start  = ptr + IDX_W'(1);
   assign held   = req[ptr];
   assign others = |(req & ~(4'b0001 << ptr));

   rr_priority_pick u_pick (
      .req    (req),
      .start  (start),
      .winner (win),
      .found  (found)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         addr  <= '0;
         ptr   <= 2'd3;
         cnt   <= '0;
         en_q  <= 1'b0;
      end else begin
         state <= state_n;
         addr  <= addr_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         en_q  <= en_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = addr;
      ptr_n   = ptr;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_n = GRANT;
               addr_n  = win;
               ptr_n   = win;
               cnt_n   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!held) begin
               if (found) begin
                  addr_n = win;
                  ptr_n  = win;
                  cnt_n  = CNT_W'(1);
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end else if (cnt < MAX_C) begin
               cnt_n = cnt + CNT_W'(1);
            end else if (others) begin
               addr_n = win;
               ptr_n  = win;
               cnt_n  = CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      en_n = (state_n == GRANT);
   end

   assign enable   = en_q;
   assign address0 = addr[0];
   assign address1 = addr[1];

endmodule

// File: doc/request_arbiter.md
REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 Parameter MAX_TENURE, default 4, SHALL set the maximum consecutive grant cycles per owner while others wait; legal range 1..7.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  4  SHALL carry one request bit per requester; bit i = requester i.
REQ-005 address0  output  1  SHALL be the LSB of the granted requester index.
REQ-006 address1  output  1  SHALL be the MSB of the granted requester index.
REQ-007 enable  output  1  SHALL be high exactly when a grant is active.
REQ-008 address0, address1 and enable SHALL connect directly to the 2-to-4 decoder's address0/address1/enable, with no glue logic.

Function
REQ-009 All outputs SHALL be driven from flops; there is no combinational path from req to any output.
REQ-010 States SHALL be IDLE (enable=0) and GRANT (enable=1).
REQ-011 A 2-bit pointer SHALL hold the last owner; arbitration SHALL search req from pointer+1 upward, wrapping 3->0, and pick the first set bit.
REQ-012 IDLE, req nonzero: the next edge SHALL enter GRANT with address = winner, tenure count = 1, pointer = winner; grant latency is 1 cycle.
REQ-013 IDLE, req zero: SHALL remain in IDLE; address SHALL hold its previous value.
REQ-014 GRANT, req[owner]=0, other requests pending: the next edge SHALL grant the next winner directly, searching from owner+1, with no idle cycle; count = 1.
REQ-015 GRANT, req[owner]=0, no other requests: the next edge SHALL return to IDLE, enable=0.
REQ-016 GRANT, req[owner]=1, count < MAX_TENURE: SHALL keep the owner; count increments.
REQ-017 GRANT, req[owner]=1, count = MAX_TENURE, another request pending: the next edge SHALL rotate to the next winner; count = 1.
REQ-018 GRANT, req[owner]=1, count = MAX_TENURE, no other request: SHALL keep the owner; count saturates at MAX_TENURE.
REQ-019 While enable=1, address0/address1 SHALL change only at a grant transition edge.
REQ-020 Requests asserted in the same cycle as an owner change SHALL be included in that cycle's search.
REQ-021 The count SHALL be 3 bits wide and SHALL never wrap.

Reset
REQ-022 While reset_n=0: state = IDLE, enable = 0, address1/address0 = 00, pointer = 3, count = 0.
REQ-023 Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-grant; enable SHALL fall without a clk edge.
REQ-024 After reset_n deasserts, the first grant SHALL search from requester 0.

Structure
REQ-025 Package arbiter_pkg SHALL hold the state encoding, the MAX_TENURE default, and the index and count width constants.
REQ-026 Sub-module rr_priority_pick SHALL implement the purely combinational wrap-around search.
  - Inputs: req, start index.
  - Outputs: winner index, found flag.
  - request_arbiter SHALL instantiate it once.

Verification
REQ-027 Reset, then req=0101 -> one cycle later enable=1, address=00; owner 0 held while req0 stays high, up to 4 cycles.
REQ-028 req=1111 held, MAX_TENURE=4 -> grant sequence 0,1,2,3,0, each held exactly 4 cycles, with no enable gap.
REQ-029 Owner 2 granted, req changes 0100->0000 -> enable=0 on the next edge; address holds 10.
REQ-030 Owner 1 granted, req changes 0010->1001 -> next edge grants 3 (search from 2), then grants 0 after owner 3 releases.
REQ-031 Only req3 set for 10 cycles -> owner 3 held continuously; count saturates at 4, with no rotation.
REQ-032 reset_n pulled low mid-grant between clock edges -> enable=0 and address=00 immediately; after release with req=1000 -> owner 3 granted after 1 cycle.
